// File: rtl/utxd_fifo_8n1_if.sv
// Host-side bundle of the 8N1 transmitter: byte strobe in, status and serial line out.
interface utxd_fifo_8n1_if;
  logic [7:0] dat;
  logic       st;
  logic       full;
  logic       ovf;
  logic       TXD;
  logic       busy;
  logic       done;

  // Host logic: pushes bytes, watches status and the line.
  modport master (
    output dat, st,
    input  full, ovf, TXD, busy, done
  );

  // Transmitter: accepts bytes, drives status and the line.
  modport slave (
    input  dat, st,
    output full, ovf, TXD, busy, done
  );
endinterface

// File: rtl/utxd_fifo_8n1.sv
// UART 8N1 transmitter fed by a small byte FIFO. Frames are sent back-to-back
// (start, 8 data bits LSB first, stop), each bit lasting Nt = Fclk/VEL clocks.
module utxd_fifo_8n1 #(
  parameter int Fclk       = 50000000,
  parameter int VEL        = 115200,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  utxd_fifo_8n1_if.slave  bus
);

  localparam int Nt    = Fclk / VEL;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(Nt + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic [TW-1:0]         cb_tact, cb_tact_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [7:0]            shift, shift_nxt;
  logic                  push, pop, empty, ce_tact, txd_nxt, done_c;

  assign empty   = (count == '0);
  // full is the registered flag, so a push in a full cycle is rejected even
  // when the FSM pops in that same cycle.
  assign push    = bus.st & ~bus.full;
  assign ce_tact = (cb_tact == TW'(Nt));
  assign bus.busy = (state != IDLE);
  assign bus.done = done_c;

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Byte storage; only written on an accepted push.
  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.dat;
  end

  // FIFO pointers, occupancy, full flag and sticky overflow.
  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bus.full <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      bus.full <= (count_nxt == (DEPTH_LOG2 + 1)'(DEPTH));
      if (bus.st && bus.full) bus.ovf <= 1'b1;
    end
  end

  // Frame sequencer: next state, bit/tact counters, shifter, pop and done.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    cb_tact_nxt = cb_tact;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    pop         = 1'b0;
    done_c      = 1'b0;
    txd_nxt     = 1'b1;
    unique case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (!empty) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          cb_tact_nxt = TW'(1);
          state_nxt   = START;
        end
      end
      START: begin
        txd_nxt = 1'b0;
        if (ce_tact) begin
          cb_tact_nxt = TW'(1);
          bit_cnt_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          cb_tact_nxt = cb_tact + TW'(1);
        end
      end
      DATA: begin
        txd_nxt = shift[0];
        if (ce_tact) begin
          cb_tact_nxt = TW'(1);
          shift_nxt   = shift >> 1;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end else begin
          cb_tact_nxt = cb_tact + TW'(1);
        end
      end
      STOP: begin
        txd_nxt = 1'b1;
        if (ce_tact) begin
          done_c = 1'b1;
          if (!empty) begin
            // Chain straight into the next frame with no idle gap.
            pop         = 1'b1;
            shift_nxt   = mem[rd_ptr];
            cb_tact_nxt = TW'(1);
            state_nxt   = START;
          end else begin
            cb_tact_nxt = '0;
            state_nxt   = IDLE;
          end
        end else begin
          cb_tact_nxt = cb_tact + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer registers; TXD is taken from the current state, so the line
  // lags the FSM by one clock and is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cb_tact <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      bus.TXD <= 1'b1;
    end else begin
      state   <= state_nxt;
      cb_tact <= cb_tact_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      bus.TXD <= txd_nxt;
    end
  end

endmodule
